rvfi_trace_arbiter: RTL and testbench

RVFI_TRACE_ARBITER -- requirements
Module: rvfi_trace_arbiter

---
 rtl/rvfi_trace_arb_pkg.sv | 25 ++
 rtl/rvfi_trace_arbiter_if.sv | 33 +++
 rtl/rvfi_trace_fifo.sv | 71 +++++++
 rtl/rvfi_trace_arbiter.sv | 164 ++++++++++++++++
 tb/tb_rvfi_trace_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rvfi_trace_arb_pkg.sv
// rvfi_trace_arb_pkg: shared types for the RVFI trace arbiter.
// Holds the commit record layout, FSM states and the timeout code.
package rvfi_trace_arb_pkg;

    localparam int unsigned PADDR_W = 64;

    localparam logic [31:0] TIMEOUT_CODE = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [63:0]        pc;
        logic [31:0]        insn;
        logic               trap;
        logic [63:0]        cause;
        logic [7:0]         mem_wmask;
        logic [PADDR_W-1:0] mem_paddr;
        logic [63:0]        mem_wdata;
    } trace_rec_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } arb_state_e;

endpackage

// File: rtl/rvfi_trace_arbiter_if.sv
// rvfi_trace_arbiter_if: commit-port inputs and merged output stream.
// slave = arbiter side, master = core/sink side.
interface rvfi_trace_arbiter_if #(
    parameter int unsigned NR_PORTS = 2
);
    import rvfi_trace_arb_pkg::*;

    logic [NR_PORTS-1:0]    rec_valid_i;
    trace_rec_t [NR_PORTS-1:0] rec_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    trace_rec_t             out_rec_o;
    logic [1:0]             out_port_o;

    modport master (
        output rec_valid_i,
        output rec_i,
        output out_ready_i,
        input  out_valid_o,
        input  out_rec_o,
        input  out_port_o
    );

    modport slave (
        input  rec_valid_i,
        input  rec_i,
        input  out_ready_i,
        output out_valid_o,
        output out_rec_o,
        output out_port_o
    );

endinterface

// File: rtl/rvfi_trace_fifo.sv
// rvfi_trace_fifo: multi-write, single-read record FIFO with port tag.
// Writers are packed in ascending port order; DEPTH is a power of two >= 2.
module rvfi_trace_fifo
    import rvfi_trace_arb_pkg::*;
#(
    parameter int unsigned NR_PORTS = 2,
    parameter int unsigned DEPTH    = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NR_PORTS-1:0]       wr_en,
    input  trace_rec_t [NR_PORTS-1:0] wr_rec,
    input  logic                      rd_en,
    output trace_rec_t                rd_rec,
    output logic [1:0]                rd_port,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    trace_rec_t     mem_rec  [DEPTH];
    logic [1:0]     mem_port [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_idx [NR_PORTS];
    logic [CW-1:0]  n_wr;
    logic           rd_fire;

    assign rd_fire = rd_en && (count != '0);

    // slot for each enabled writer, packed behind the lower ports
    always_comb begin
        n_wr = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            wr_idx[p] = wr_ptr + n_wr[AW-1:0];
            if (wr_en[p]) begin
                n_wr = n_wr + CW'(1);
            end
        end
    end

    // storage array, no reset needed: head is masked when empty
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NR_PORTS; p++) begin
            if (wr_en[p]) begin
                mem_rec[wr_idx[p]]  <= wr_rec[p];
                mem_port[wr_idx[p]] <= 2'(p);
            end
        end
    end

    // pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + n_wr[AW-1:0];
            if (rd_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + n_wr - CW'(rd_fire);
        end
    end

    assign rd_rec  = (count != '0) ? mem_rec[rd_ptr]  : '0;
    assign rd_port = (count != '0) ? mem_port[rd_ptr] : '0;

endmodule

// File: rtl/rvfi_trace_arbiter.sv
// rvfi_trace_arbiter: merges commit ports into one trace stream, detects end of test.
// Optional stats outputs (drop count, peak occupancy) under RVFI_TRACE_ARB_STATS_EN.
module rvfi_trace_arbiter
    import rvfi_trace_arb_pkg::*;
#(
    parameter int unsigned NR_PORTS = 2,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned PLEN     = 56
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [PLEN-1:0]    cfg_tohost_addr_i,
    input  logic [31:0]        cfg_timeout_i,
    rvfi_trace_arbiter_if.slave bus,
    output logic               overflow_o,
`ifdef RVFI_TRACE_ARB_STATS_EN
    output logic [15:0]        drop_count_o,
    output logic [$clog2(DEPTH):0] max_occ_o,
`endif
    output logic [31:0]        end_of_test_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    arb_state_e          state;
    logic [31:0]         cycle_cnt;
    logic [31:0]         code_q;
    logic [CW-1:0]       fifo_count;
    logic [CW-1:0]       free;
    logic [CW-1:0]       used;
    logic [NR_PORTS-1:0] hit;
    logic [NR_PORTS-1:0] accept;
    logic [2:0]          n_drop;
    logic                alive;
    logic                tohost_any;
    logic [31:0]         tohost_code;
    logic                timeout_hit;
    logic                terminate;
    logic                out_valid;
    trace_rec_t          head_rec;
    logic [1:0]          head_port;

    // per-port tohost store detection
    always_comb begin
        hit = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            hit[p] = bus.rec_valid_i[p]
                  && !bus.rec_i[p].trap
                  && (bus.rec_i[p].mem_wmask != '0)
                  && (cfg_tohost_addr_i != '0)
                  && (bus.rec_i[p].mem_paddr[PLEN-1:0] == cfg_tohost_addr_i)
                  && bus.rec_i[p].mem_wdata[0];
        end
    end

    // admit records in port order up to start-of-cycle free space
    always_comb begin
        accept      = '0;
        used        = '0;
        n_drop      = '0;
        alive       = 1'b1;
        tohost_any  = 1'b0;
        tohost_code = '0;
        free        = CW'(DEPTH) - fifo_count;
        if (state == RUN) begin
            for (int p = 0; p < NR_PORTS; p++) begin
                if (alive && bus.rec_valid_i[p]) begin
                    if (used < free) begin
                        accept[p] = 1'b1;
                        used      = used + CW'(1);
                    end else begin
                        n_drop = n_drop + 3'd1;
                    end
                    if (hit[p]) begin
                        alive       = 1'b0;
                        tohost_any  = 1'b1;
                        tohost_code = bus.rec_i[p].mem_wdata[31:0];
                    end
                end
            end
        end
    end

    assign timeout_hit = (state == RUN)
                      && (cfg_timeout_i != '0)
                      && (cycle_cnt == cfg_timeout_i);
    assign terminate   = tohost_any || timeout_hit;

    assign out_valid       = (fifo_count != '0);
    assign bus.out_valid_o = out_valid;
    assign bus.out_rec_o   = head_rec;
    assign bus.out_port_o  = head_port;

    rvfi_trace_fifo #(
        .NR_PORTS (NR_PORTS),
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_en   (accept),
        .wr_rec  (bus.rec_i),
        .rd_en   (out_valid && bus.out_ready_i),
        .rd_rec  (head_rec),
        .rd_port (head_port),
        .count   (fifo_count)
    );

    // run/drain/done sequencing with registered status outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= RUN;
            cycle_cnt     <= '0;
            code_q        <= '0;
            overflow_o    <= 1'b0;
            end_of_test_o <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    cycle_cnt <= cycle_cnt + 32'd1;
                    if (n_drop != '0) begin
                        overflow_o <= 1'b1;
                    end
                    if (terminate) begin
                        state  <= DRAIN;
                        code_q <= tohost_any ? tohost_code : TIMEOUT_CODE;
                    end
                end
                DRAIN: begin
                    if (fifo_count == '0) begin
                        state         <= DONE;
                        end_of_test_o <= code_q;
                    end
                end
                DONE: begin
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

`ifdef RVFI_TRACE_ARB_STATS_EN
    logic [16:0] drop_sum;

    assign drop_sum = {1'b0, drop_count_o} + 17'(n_drop);

    // saturating drop counter and occupancy high-water mark
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_count_o <= '0;
            max_occ_o    <= '0;
        end else begin
            if (n_drop != '0) begin
                drop_count_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
            if (fifo_count > max_occ_o) begin
                max_occ_o <= fifo_count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rvfi_trace_arbiter.sv
// tb_rvfi_trace_arbiter: directed checks of merge order, overflow, tohost,
// timeout and reset behaviour of rvfi_trace_arbiter.
module tb_rvfi_trace_arbiter;
    import rvfi_trace_arb_pkg::*;

    localparam int unsigned NR_PORTS = 2;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned PLEN     = 56;
    localparam logic [PLEN-1:0] TOHOST = 56'h8000_1000;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b0;
    logic [PLEN-1:0] cfg_tohost_addr_i;
    logic [31:0]     cfg_timeout_i;
    logic            overflow_o;
    logic [31:0]     end_of_test_o;
`ifdef RVFI_TRACE_ARB_STATS_EN
    logic [15:0]     drop_count_o;
    logic [$clog2(DEPTH):0] max_occ_o;
`endif

    int n_checks = 0;
    int n_errs   = 0;

    rvfi_trace_arbiter_if #(.NR_PORTS(NR_PORTS)) bus ();

    rvfi_trace_arbiter #(
        .NR_PORTS (NR_PORTS),
        .DEPTH    (DEPTH),
        .PLEN     (PLEN)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .cfg_tohost_addr_i (cfg_tohost_addr_i),
        .cfg_timeout_i     (cfg_timeout_i),
        .bus               (bus),
        .overflow_o        (overflow_o),
`ifdef RVFI_TRACE_ARB_STATS_EN
        .drop_count_o      (drop_count_o),
        .max_occ_o         (max_occ_o),
`endif
        .end_of_test_o     (end_of_test_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic trace_rec_t mk(input logic [63:0] pc,
                                      input logic [63:0] paddr,
                                      input logic [63:0] wdata,
                                      input logic [7:0]  wmask);
        trace_rec_t r;
        r           = '0;
        r.pc        = pc;
        r.insn      = 32'h0000_0013;
        r.mem_paddr = paddr;
        r.mem_wdata = wdata;
        r.mem_wmask = wmask;
        return r;
    endfunction

    function automatic trace_rec_t plain(input logic [63:0] pc);
        return mk(pc, 64'h0, 64'h0, 8'h0);
    endfunction

    task automatic drive(input logic [1:0] v, input trace_rec_t r0,
                         input trace_rec_t r1);
        bus.rec_valid_i = v;
        bus.rec_i[0]    = r0;
        bus.rec_i[1]    = r1;
    endtask

    task automatic idle();
        drive(2'b00, '0, '0);
    endtask

    task automatic do_reset(input logic [31:0] tmo,
                            input logic [PLEN-1:0] th,
                            input logic rdy);
        rst_i             = 1'b1;
        cfg_timeout_i     = tmo;
        cfg_tohost_addr_i = th;
        bus.out_ready_i   = rdy;
        idle();
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic expect_head(input string tag, input logic [63:0] pc,
                               input logic [1:0] port);
        check({tag, ".valid"}, bus.out_valid_o, 64'd1);
        check({tag, ".pc"}, bus.out_rec_o.pc, pc);
        check({tag, ".port"}, bus.out_port_o, port);
    endtask

    task automatic wait_eot(input int limit);
        int n = 0;
        while (end_of_test_o == '0 && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] t3_pc   [7];
        logic [1:0]  t3_port [7];
        logic [63:0] t4_pc   [3];
        logic [1:0]  t4_port [3];
        int          n;

        t3_pc   = '{64'h3004, 64'h3008, 64'h300C, 64'h3010,
                    64'h3014, 64'h3030, 64'h3040};
        t3_port = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0};
        t4_pc   = '{64'h4000, 64'h4004, 64'h4008};
        t4_port = '{2'd0, 2'd1, 2'd0};

        cfg_timeout_i     = '0;
        cfg_tohost_addr_i = '0;
        bus.out_ready_i   = 1'b0;
        idle();

        // reset state
        #2 rst_i = 1'b1;
        #1;
        check("rst.valid", bus.out_valid_o, 64'd0);
        check("rst.ovf", overflow_o, 64'd0);
        check("rst.eot", end_of_test_o, 64'd0);
        check("rst.pc", bus.out_rec_o.pc, 64'd0);
        check("rst.port", bus.out_port_o, 64'd0);

        // two ports in one cycle come out in port order
        do_reset(32'd0, '0, 1'b1);
        drive(2'b11, plain(64'h1000), plain(64'h1004));
        tick();
        idle();
        expect_head("t1.a", 64'h1000, 2'd0);
        tick();
        expect_head("t1.b", 64'h1004, 2'd1);
        tick();
        check("t1.empty", bus.out_valid_o, 64'd0);

        // overflow with sink stalled
        do_reset(32'd0, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(2'b11, plain(64'h2000 + 64'(8 * i)),
                  plain(64'h2004 + 64'(8 * i)));
            tick();
            if (i == 3) check("t2.ovf_full", overflow_o, 64'd0);
        end
        idle();
        check("t2.ovf", overflow_o, 64'd1);
`ifdef RVFI_TRACE_ARB_STATS_EN
        check("t2.drops", drop_count_o, 64'd2);
        check("t2.maxocc", max_occ_o, 64'd8);
`endif
        expect_head("t2.hold0", 64'h2000, 2'd0);
        tick();
        expect_head("t2.hold1", 64'h2000, 2'd0);
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            expect_head("t2.drain", 64'h2000 + 64'(4 * i), 2'(i % 2));
            tick();
        end
        check("t2.empty", bus.out_valid_o, 64'd0);

        // partial fit, and a same-cycle pop does not free space
        do_reset(32'd0, '0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, plain(64'h3000 + 64'(8 * i)),
                  plain(64'h3004 + 64'(8 * i)));
            tick();
        end
        drive(2'b01, plain(64'h3030), '0);
        tick();
        check("t3.ovf7", overflow_o, 64'd0);
        drive(2'b11, plain(64'h3040), plain(64'h3044));
        tick();
        check("t3.ovf", overflow_o, 64'd1);
        bus.out_ready_i = 1'b1;
        drive(2'b01, plain(64'h3050), '0);
        tick();
        idle();
`ifdef RVFI_TRACE_ARB_STATS_EN
        check("t3.drops", drop_count_o, 64'd2);
`endif
        for (int i = 0; i < 7; i++) begin
            expect_head("t3.drain", t3_pc[i], t3_port[i]);
            tick();
        end
        check("t3.empty", bus.out_valid_o, 64'd0);

        // tohost store ends the test after draining
        do_reset(32'd0, TOHOST, 1'b0);
        drive(2'b11, plain(64'h4000),
              mk(64'h4004, 64'(TOHOST), 64'h2, 8'h0F));
        tick();
        drive(2'b11, mk(64'h4008, 64'(TOHOST), 64'h1, 8'h0F),
              plain(64'h400C));
        tick();
        idle();
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_head("t4.drain", t4_pc[i], t4_port[i]);
            check("t4.eot_drain", end_of_test_o, 64'd0);
            tick();
        end
        check("t4.empty", bus.out_valid_o, 64'd0);
        check("t4.eot_pre", end_of_test_o, 64'd0);
        tick();
        check("t4.eot", end_of_test_o, 64'd1);
        check("t4.ovf", overflow_o, 64'd0);
        drive(2'b11, mk(64'h4100, 64'(TOHOST), 64'h5, 8'h1),
              plain(64'h4104));
        repeat (3) tick();
        idle();
        check("t4.eot_held", end_of_test_o, 64'd1);
        check("t4.ignored", bus.out_valid_o, 64'd0);

        // timeout with no tohost
        do_reset(32'd100, '0, 1'b1);
        n = 0;
        while (end_of_test_o == '0 && n < 300) begin
            tick();
            n++;
        end
        check("t5.latency", 64'(n), 64'd102);
        check("t5.eot", end_of_test_o, 64'hFFFF_FFFF);
        repeat (10) tick();
        check("t5.held", end_of_test_o, 64'hFFFF_FFFF);

        // tohost on the timeout cycle wins
        do_reset(32'd5, TOHOST, 1'b1);
        repeat (5) tick();
        drive(2'b01, mk(64'h6000, 64'(TOHOST),
                        64'h1234_5678_0000_0043, 8'hFF), '0);
        tick();
        idle();
        wait_eot(20);
        check("t6.tie", end_of_test_o, 64'h0000_0043);

        // one cycle later the timeout has already fired
        do_reset(32'd5, TOHOST, 1'b1);
        repeat (6) tick();
        drive(2'b01, mk(64'h6000, 64'(TOHOST),
                        64'h1234_5678_0000_0043, 8'hFF), '0);
        tick();
        idle();
        wait_eot(20);
        check("t6.late", end_of_test_o, 64'hFFFF_FFFF);

        // reset while draining
        do_reset(32'd0, TOHOST, 1'b0);
        drive(2'b11, plain(64'h7000), plain(64'h7004));
        tick();
        drive(2'b11, plain(64'h7008),
              mk(64'h700C, 64'(TOHOST), 64'h1, 8'h1));
        tick();
        idle();
        tick();
        expect_head("t7.buf", 64'h7000, 2'd0);
        #2 rst_i = 1'b1;
        #1;
        check("t7.valid_async", bus.out_valid_o, 64'd0);
        check("t7.eot", end_of_test_o, 64'd0);
        check("t7.pc", bus.out_rec_o.pc, 64'd0);
        tick();
        rst_i = 1'b0;
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t7.no_stale", bus.out_valid_o, 64'd0);
        end
        drive(2'b01, plain(64'h7100), '0);
        tick();
        idle();
        expect_head("t7.resume", 64'h7100, 2'd0);
        tick();
        check("t7.eot_run", end_of_test_o, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errs);
        $finish;
    end

endmodule
